cpu_wb_arbiter: RTL and testbench
=================================

# cpu_wb_arbiter

Write-side master for the CPU register file. It collects results from the pipeline's functional units (ALU, multiply/divide unit, load/store unit) through per-source valid/ready handshakes. It buffers one result per source and arbitrates them round-robin onto the register file's single write port (we/waddr/wdata). It sits between the execute/memory completion buses and the register file, and drives the write port with registered outputs only.

## Interface
Parameters:
- NSRC, 3, number of result sources (index 0 = ALU, 1 = MDU, 2 = LSU)
- DW, 32, result data width
- RW, 5, destination register index width on source side

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- src_valid  in  NSRC  result offered by source i
- src_ready  out  NSRC  source i result accepted this cycle
- src_rd  in  NSRC*RW  destination register of source i (slice i)
- src_data  in  NSRC*DW  result value of source i (slice i)
- we  out  1  register file write enable
- waddr  out  32  register file write address, zero-extended rd
- wdata  out  32  register file write data
- wb_count  out  32  number of register writes issued since reset

## Operation
- Holding register per source: hold_v[i], hold_rd[i], hold_data[i].
- src_ready[i] = ~hold_v[i] | grant[i] (combinational; a granted slot is refilled in the same cycle).
- Accept on src_valid[i] & src_ready[i]:
  - if src_rd[i] != 0, the entry is loaded into the slot and hold_v[i] is set;
  - if src_rd[i] == 0, the entry is consumed and discarded. The slot is not loaded and no write or count results. Register $0 is never written.
- Arbitration: among hold_v, the first set index scanning ptr, ptr+1, ... (mod NSRC) gets grant (one-hot, at most one).
  - On grant to i: ptr <= (i+1) mod NSRC, and hold_v[i] is cleared unless refilled that cycle.
  - ptr is unchanged when nothing is granted.
- Output register: on a grant, we <= 1, waddr <= {27'b0, hold_rd[i]}, wdata <= hold_data[i], and wb_count <= wb_count + 1 (wraps at 2^32). With no grant, we <= 0 and waddr/wdata hold their last value.
- Reset (asynchronous, any time, including mid-transfer): all hold_v = 0, ptr = 0, we = 0, waddr = 0, wdata = 0, wb_count = 0. In-flight results are lost, and src_ready is all ones once reset deasserts.

## Timing
- Latency: a result accepted at edge N is granted in cycle N+1 at the earliest. we/waddr/wdata are valid in the cycle after edge N+1.
- Throughput: one write per cycle. Each source sustains one result every cycle while it is the only requester, and one result per NSRC cycles under full contention.
- Starvation bound: a held entry is granted within NSRC cycles.
- Simultaneous events:
  - A grant and a new accept on the same slot in one cycle: the slot holds the new entry and hold_v stays 1.
  - Same rd from two sources: the writes are issued in grant order, and the later grant wins in the register file.
- we is a single-cycle pulse per write; it never stays high without a new grant.

## Structure
- Shared CPU package: source index constants (SRC_ALU = 0, SRC_MDU = 1, SRC_LSU = 2), NSRC, register index width, and the zero-register constant.
- One sub-module: cpu_rr_arbiter. Inputs are the request vector and ptr; output is the one-hot grant. It is purely combinational and parameterized by NSRC.
- Holding slots, ptr, output register and counter are in the top module.

## Test plan
- Single write: reset, then ALU offers rd = 5, data = 0xDEADBEEF for one cycle -> src_ready[0] = 1. Two edges later there is one pulse with we = 1, waddr = 5, wdata = 0xDEADBEEF, and wb_count = 1.
- $0 discard: LSU offers rd = 0, data = 0x12345678 -> accepted (src_ready[2] = 1), we never asserts, wb_count stays 0.
- Contention: all three sources hold valid with rd = 1/2/3 continuously -> writes issue in order waddr 1, 2, 3, 1, 2, 3... with no idle cycle and each source granted every third cycle.
- Back-to-back single source: MDU streams rd = 7..10 every cycle with no other traffic -> src_ready[1] stays 1, and four consecutive we pulses carry waddr 7, 8, 9, 10.
- Pointer rotation: after a grant to source 2, sources 0 and 1 request together -> source 0 is granted first (ptr = 0), then source 1.
- Reset mid-operation: assert rst_n = 0 while two slots are full and we = 1 -> we, waddr, wdata and wb_count drop to 0 immediately. After release there are no writes, and src_ready = 3'b111.

Source files
------------

// File: rtl/cpu_wb_arbiter_pkg.sv
// Shared CPU write-back constants: source indices, register index width,
// and the hard-wired zero register.
package cpu_wb_arbiter_pkg;
  localparam int SRC_ALU = 0;
  localparam int SRC_MDU = 1;
  localparam int SRC_LSU = 2;
  localparam int NSRC    = 3;
  localparam int REG_W   = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/cpu_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found scanning ptr, ptr+1, ... (mod N).
module cpu_rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic found;
  int   idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cpu_wb_arbiter.sv
// Register-file write-back master: one holding slot per result source,
// round-robin onto a single registered write port.
module cpu_wb_arbiter
  import cpu_wb_arbiter_pkg::*;
#(
  parameter int NSRC = cpu_wb_arbiter_pkg::NSRC,
  parameter int DW   = 32,
  parameter int RW   = REG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSRC-1:0]    src_valid,
  output logic [NSRC-1:0]    src_ready,
  input  logic [NSRC*RW-1:0] src_rd,
  input  logic [NSRC*DW-1:0] src_data,
  output logic               we,
  output logic [31:0]        waddr,
  output logic [DW-1:0]      wdata,
  output logic [31:0]        wb_count
);
  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]         hold_v_q, hold_v_d;
  logic [NSRC-1:0][RW-1:0] hold_rd_q;
  logic [NSRC-1:0][DW-1:0] hold_data_q;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NSRC-1:0]         grant, load;
  logic [PW-1:0]           gidx;
  logic                    any_grant;
  logic                    we_q;
  logic [31:0]             waddr_q, wb_count_q;
  logic [DW-1:0]           wdata_q;

  cpu_rr_arbiter #(.N(NSRC), .PW(PW)) u_rr (
    .req_i (hold_v_q),
    .ptr_i (ptr_q),
    .gnt_o (grant)
  );

  assign src_ready = ~hold_v_q | grant;
  assign any_grant = |grant;

  // rd == $0 is accepted but never loaded, so it can never produce a write.
  always_comb begin
    load = '0;
    gidx = '0;
    for (int i = 0; i < NSRC; i++) begin
      load[i] = src_valid[i] & src_ready[i] & (src_rd[i*RW +: RW] != REG_ZERO);
      if (grant[i]) gidx = PW'(i);
    end
    hold_v_d = load | (hold_v_q & ~grant);
    ptr_d    = ptr_q;
    if (any_grant) ptr_d = (int'(gidx) == NSRC-1) ? '0 : gidx + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q    <= '0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
      ptr_q       <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      ptr_q    <= ptr_d;
      for (int i = 0; i < NSRC; i++) begin
        if (load[i]) begin
          hold_rd_q[i]   <= src_rd[i*RW +: RW];
          hold_data_q[i] <= src_data[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wb_count_q <= '0;
    end else begin
      we_q <= any_grant;
      if (any_grant) begin
        waddr_q    <= 32'(hold_rd_q[gidx]);
        wdata_q    <= hold_data_q[gidx];
        wb_count_q <= wb_count_q + 32'd1;
      end
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign wb_count = wb_count_q;
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Directed bench for cpu_wb_arbiter; inputs driven and outputs sampled on negedge.
module tb_cpu_wb_arbiter;
  import cpu_wb_arbiter_pkg::*;
  localparam int N = 3, DW = 32, RW = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      src_valid = '0;
  logic [N-1:0]      src_ready;
  logic [N*RW-1:0]   src_rd = '0;
  logic [N*DW-1:0]   src_data = '0;
  logic              we;
  logic [31:0]       waddr, wdata, wb_count;
  int checks = 0, errors = 0;

  cpu_wb_arbiter #(.NSRC(N), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_data(src_data), .we(we), .waddr(waddr),
    .wdata(wdata), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic offer(input int i, input logic [RW-1:0] rd, input logic [DW-1:0] d);
    src_valid[i]          = 1'b1;
    src_rd[i*RW +: RW]    = rd;
    src_data[i*DW +: DW]  = d;
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", waddr, 32'd0);
    chk("rst_count", wb_count, 32'd0);
    step(); step();
    rst_n = 1'b1;
    chk("rst_ready", 32'(src_ready), 32'h7);

    // $0 discard from LSU
    offer(SRC_LSU, 5'd0, 32'h12345678);
    chk("z_ready", 32'(src_ready[SRC_LSU]), 32'd1);
    step(); idle();
    for (int k = 0; k < 4; k++) begin
      chk("z_we", 32'(we), 32'd0);
      step();
    end
    chk("z_count", wb_count, 32'd0);

    // Single write from ALU
    offer(SRC_ALU, 5'd5, 32'hDEADBEEF);
    chk("s_ready", 32'(src_ready[SRC_ALU]), 32'd1);
    step(); idle();
    chk("s_we_early", 32'(we), 32'd0);
    step();
    chk("s_we", 32'(we), 32'd1);
    chk("s_waddr", waddr, 32'd5);
    chk("s_wdata", wdata, 32'hDEADBEEF);
    chk("s_count", wb_count, 32'd1);
    step();
    chk("s_we_pulse", 32'(we), 32'd0);
    chk("s_waddr_hold", waddr, 32'd5);

    // Pointer rotation: ptr=1, LSU alone -> grant 2, then ALU/MDU together
    offer(SRC_LSU, 5'd4, 32'h44);
    step(); idle();
    offer(SRC_ALU, 5'd20, 32'h20);
    offer(SRC_MDU, 5'd21, 32'h21);
    step(); idle();
    chk("r_waddr0", waddr, 32'd4);
    step();
    chk("r_waddr1", waddr, 32'd20);
    chk("r_wdata1", wdata, 32'h20);
    step();
    chk("r_waddr2", waddr, 32'd21);
    step();
    chk("r_we_idle", 32'(we), 32'd0);
    chk("r_count", wb_count, 32'd4);

    // Back-to-back MDU stream rd 7..10
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        chk("b_we", 32'(we), 32'd1);
        chk("b_waddr", waddr, 32'(5 + k));
      end
      if (k < 4) begin
        offer(SRC_MDU, 5'(7 + k), 32'(32'h700 + k));
        chk("b_ready", 32'(src_ready[SRC_MDU]), 32'd1);
      end else idle();
      step();
    end
    chk("b_we_end", 32'(we), 32'd0);
    chk("b_count", wb_count, 32'd8);

    // Reset mid-operation: two slots still full while we is high
    offer(SRC_ALU, 5'd11, 32'hB1);
    offer(SRC_MDU, 5'd12, 32'hB2);
    offer(SRC_LSU, 5'd13, 32'hB3);
    step(); idle();
    step();
    chk("m_we_pre", 32'(we), 32'd1);
    chk("m_waddr_pre", waddr, 32'd13);
    #2 rst_n = 1'b0;
    #1;
    chk("m_we", 32'(we), 32'd0);
    chk("m_waddr", waddr, 32'd0);
    chk("m_wdata", wdata, 32'd0);
    chk("m_count", wb_count, 32'd0);
    step(); step();
    rst_n = 1'b1;
    chk("m_ready", 32'(src_ready), 32'h7);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("m_we_post", 32'(we), 32'd0);
    end
    chk("m_count_post", wb_count, 32'd0);

    // Full contention, ptr = 0 after reset
    offer(SRC_ALU, 5'd1, 32'hA1);
    offer(SRC_MDU, 5'd2, 32'hA2);
    offer(SRC_LSU, 5'd3, 32'hA3);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("c_ready", 32'(src_ready), 32'(1 << ((k - 1) % 3)));
      if (k >= 2) begin
        chk("c_we", 32'(we), 32'd1);
        chk("c_waddr", waddr, 32'(1 + (k - 2) % 3));
        chk("c_wdata", wdata, 32'(32'hA1 + (k - 2) % 3));
      end
    end
    chk("c_count", wb_count, 32'd6);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
